// File: rtl/backoff_retry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : backoff_retry_pkg
// Description : Shared types for the backoff retry controller. Holds the
//               controller state encoding used by backoff_retry_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package backoff_retry_pkg;

    // Controller state encoding (explicit 3-bit width)
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_RSP = 3'd2,
        ARM      = 3'd3,
        BACKOFF  = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage : backoff_retry_pkg
`default_nettype wire

// File: rtl/backoff_retry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : backoff_retry_ctrl
// Description : Retry controller that drives an exponential backoff counter
//               (set/clr/is_zero). Accepts one transaction, issues it
//               downstream, inspects the response and, on failure, arms the
//               backoff counter and re-issues once it expires, up to
//               MaxRetries retries. Reports ok / gave-up plus the number of
//               retries consumed on a completion handshake.
// Ports       : clk_i, rst_i             clock, async active-high reset
//               req_valid_i/req_ready_o  transaction accept (IDLE only)
//               req_data_i               transaction payload
//               att_valid_o/att_ready_i  downstream attempt handshake
//               att_data_o               latched payload
//               rsp_valid_i, rsp_ok_i    attempt outcome pulse
//               done_valid_o/done_ready_i completion handshake
//               done_err_o               1 = retries exhausted
//               done_retries_o           retries consumed
//               backoff_set_o/clr_o      one-cycle pulses to backoff counter
//               backoff_zero_i           backoff counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module backoff_retry_ctrl
    import backoff_retry_pkg::*;
#(
    parameter  int DataWidth  = 32,
    parameter  int MaxRetries = 7,
    localparam int RetryWidth = $clog2(MaxRetries + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DataWidth-1:0]  req_data_i,
    output logic                  att_valid_o,
    input  logic                  att_ready_i,
    output logic [DataWidth-1:0]  att_data_o,
    input  logic                  rsp_valid_i,
    input  logic                  rsp_ok_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic                  done_err_o,
    output logic [RetryWidth-1:0] done_retries_o,
    output logic                  backoff_set_o,
    output logic                  backoff_clr_o,
    input  logic                  backoff_zero_i
);

    localparam logic [RetryWidth-1:0] c_max_retry = RetryWidth'(MaxRetries);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [RetryWidth-1:0] r_retry;
    logic [DataWidth-1:0]  r_data;
    logic                  r_err;
    logic                  r_att_hold;

    logic                  w_req_ready;
    logic                  w_att_valid;
    logic                  w_done_valid;
    logic                  w_set;
    logic                  w_clr;
    logic                  w_at_limit;

    assign w_at_limit = (r_retry == c_max_retry);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_att_valid  = 1'b0;
        w_done_valid = 1'b0;
        w_set        = 1'b0;
        w_clr        = 1'b0;

        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                // Only offer once the backoff has drained; once offered, the
                // hold flag keeps valid up until the downstream accepts.
                w_att_valid = backoff_zero_i | r_att_hold;
                if (w_att_valid && att_ready_i) begin
                    w_state_nxt = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_ok_i || w_at_limit) begin
                        w_clr       = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_set       = 1'b1;
                        w_state_nxt = ARM;
                    end
                end
            end

            // The backoff counter is loading this cycle, so its zero flag is
            // stale and deliberately not looked at.
            ARM: begin
                w_state_nxt = BACKOFF;
            end

            BACKOFF: begin
                if (backoff_zero_i) begin
                    w_state_nxt = ISSUE;
                end
            end

            DONE: begin
                w_done_valid = 1'b1;
                if (done_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: payload, retry count, error flag, attempt hold
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retry    <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_att_hold <= 1'b0;
        end else begin
            r_att_hold <= w_att_valid & ~att_ready_i;

            if (r_state == IDLE && req_valid_i) begin
                r_data  <= req_data_i;
                r_retry <= '0;
            end

            if (r_state == WAIT_RSP && rsp_valid_i) begin
                r_err <= ~rsp_ok_i & w_at_limit;
                // At the limit a failure ends the transaction, so the count
                // never advances past MaxRetries.
                if (!rsp_ok_i && !w_at_limit) begin
                    r_retry <= r_retry + RetryWidth'(1);
                end
            end
        end
    end

    assign req_ready_o    = w_req_ready;
    assign att_valid_o    = w_att_valid;
    assign att_data_o     = r_data;
    assign done_valid_o   = w_done_valid;
    assign done_err_o     = w_done_valid & r_err;
    assign done_retries_o = w_done_valid ? r_retry : '0;
    assign backoff_set_o  = w_set;
    assign backoff_clr_o  = w_clr;

endmodule : backoff_retry_ctrl
`default_nettype wire

// File: tb/tb_backoff_retry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_backoff_retry_ctrl
// Description : Directed self-checking bench for backoff_retry_ctrl with a
//               behavioural backoff counter (load on set, clear on clr,
//               count down to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_backoff_retry_ctrl;

    localparam int DW = 32;
    localparam int MR = 7;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic          att_valid;
    logic          att_ready;
    logic [DW-1:0] att_data;
    logic          rsp_valid;
    logic          rsp_ok;
    logic          done_valid;
    logic          done_ready;
    logic          done_err;
    logic [RW-1:0] done_retries;
    logic          backoff_set;
    logic          backoff_clr;
    logic          backoff_zero;

    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] exp_data = '0;
    int            bo_load  = 0;
    logic [7:0]    bo_cnt;

    int cyc    = 0;
    int n_set  = 0;
    int n_clr  = 0;
    int n_att  = 0;
    int n_busy = 0;
    int n_dbad = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    backoff_retry_ctrl #(
        .DataWidth  (DW),
        .MaxRetries (MR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .att_valid_o    (att_valid),
        .att_ready_i    (att_ready),
        .att_data_o     (att_data),
        .rsp_valid_i    (rsp_valid),
        .rsp_ok_i       (rsp_ok),
        .done_valid_o   (done_valid),
        .done_ready_i   (done_ready),
        .done_err_o     (done_err),
        .done_retries_o (done_retries),
        .backoff_set_o  (backoff_set),
        .backoff_clr_o  (backoff_clr),
        .backoff_zero_i (backoff_zero)
    );

    // Behavioural backoff counter
    always @(posedge clk or posedge rst) begin
        if (rst)                bo_cnt <= 8'd0;
        else if (backoff_set)   bo_cnt <= 8'(bo_load);
        else if (backoff_clr)   bo_cnt <= 8'd0;
        else if (bo_cnt != 8'd0) bo_cnt <= bo_cnt - 8'd1;
    end
    assign backoff_zero = (bo_cnt == 8'd0);

    // Event counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (backoff_set)                 n_set  <= n_set + 1;
            if (backoff_clr)                 n_clr  <= n_clr + 1;
            if (att_valid && att_ready)      n_att  <= n_att + 1;
            if (att_valid && !backoff_zero)  n_busy <= n_busy + 1;
            if (att_valid && att_data !== exp_data) n_dbad <= n_dbad + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_req(input logic [DW-1:0] d);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = d;
        exp_data  = d;
        @(negedge clk);
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_att(output bit to);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (att_valid && att_ready) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic respond(input logic ok);
        @(posedge clk); #1;
        rsp_valid = 1'b1;
        rsp_ok    = ok;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        rsp_ok    = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic finish_done;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_data = '0; att_ready = 1'b1;
        rsp_valid = 0; rsp_ok = 0; done_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (att_valid !== 1'b0) begin errors++; $display("FAIL reset_att_valid: got %b expected 0", att_valid); end
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
        checks++; if ({backoff_set, backoff_clr} !== 2'b00) begin errors++; $display("FAIL reset_set_clr: got %b expected 00", {backoff_set, backoff_clr}); end
        checks++; if (att_data !== '0) begin errors++; $display("FAIL reset_att_data: got %0h expected 0", att_data); end
        checks++; if ({done_err, done_retries} !== 4'b0) begin errors++; $display("FAIL reset_done_fields: got %b expected 0000", {done_err, done_retries}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_ok;
        int s_set, s_clr; bit to;
        s_set = n_set; s_clr = n_clr; bo_load = 0;
        start_req(32'hA5A5_0001);
        wait_att(to);
        checks++; if (to) begin errors++; $display("FAIL single_att: got timeout expected attempt"); end
        checks++; if (cyc - acc_cyc !== 1) begin errors++; $display("FAIL single_att_cycle: got %0d expected 1", cyc - acc_cyc); end
        checks++; if (att_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_att_data: got %0h expected a5a50001", att_data); end
        respond(1'b1);
        wait_done(to);
        checks++; if (to || (cyc - acc_cyc) !== 3) begin errors++; $display("FAIL single_latency: got %0d (to=%0b) expected 3", cyc - acc_cyc, to); end
        checks++; if ({done_err, done_retries} !== 4'b0000) begin errors++; $display("FAIL single_status: got err=%b ret=%0d expected err=0 ret=0", done_err, done_retries); end
        checks++; if (n_set - s_set !== 0 || n_clr - s_clr !== 1) begin errors++; $display("FAIL single_pulses: got set=%0d clr=%0d expected set=0 clr=1", n_set - s_set, n_clr - s_clr); end
        finish_done;
    endtask

    task automatic test_fail_then_ok;
        int s_set, s_clr, s_att, s_busy, s_dbad; bit to; bit any_to;
        s_set = n_set; s_clr = n_clr; s_att = n_att; s_busy = n_busy; s_dbad = n_dbad;
        bo_load = 3; any_to = 0;
        start_req(32'h0BAD_F00D);
        for (int a = 0; a < 3; a++) begin
            wait_att(to); any_to |= to;
            respond(a >= 2);
        end
        wait_done(to); any_to |= to;
        checks++; if (any_to || (cyc - acc_cyc) !== 15) begin errors++; $display("FAIL retry2_latency: got %0d (to=%0b) expected 15", cyc - acc_cyc, any_to); end
        checks++; if ({done_err, done_retries} !== {1'b0, 3'd2}) begin errors++; $display("FAIL retry2_status: got err=%b ret=%0d expected err=0 ret=2", done_err, done_retries); end
        checks++; if (n_set - s_set !== 2 || n_clr - s_clr !== 1) begin errors++; $display("FAIL retry2_pulses: got set=%0d clr=%0d expected set=2 clr=1", n_set - s_set, n_clr - s_clr); end
        checks++; if (n_att - s_att !== 3) begin errors++; $display("FAIL retry2_attempts: got %0d expected 3", n_att - s_att); end
        checks++; if (n_busy - s_busy !== 0) begin errors++; $display("FAIL retry2_valid_in_backoff: got %0d cycles expected 0", n_busy - s_busy); end
        checks++; if (n_dbad - s_dbad !== 0) begin errors++; $display("FAIL retry2_data_stable: got %0d bad cycles expected 0", n_dbad - s_dbad); end
        finish_done;
    endtask

    task automatic test_exhaust;
        int s_set, s_clr, s_att; bit to; bit any_to;
        s_set = n_set; s_clr = n_clr; s_att = n_att;
        bo_load = 0; any_to = 0;
        start_req(32'hDEAD_0007);
        for (int a = 0; a < MR + 1; a++) begin
            wait_att(to); any_to |= to;
            respond(1'b0);
        end
        wait_done(to); any_to |= to;
        checks++; if (any_to || (cyc - acc_cyc) !== 31) begin errors++; $display("FAIL exhaust_latency: got %0d (to=%0b) expected 31", cyc - acc_cyc, any_to); end
        checks++; if ({done_err, done_retries} !== {1'b1, 3'd7}) begin errors++; $display("FAIL exhaust_status: got err=%b ret=%0d expected err=1 ret=7", done_err, done_retries); end
        checks++; if (n_set - s_set !== 7 || n_clr - s_clr !== 1) begin errors++; $display("FAIL exhaust_pulses: got set=%0d clr=%0d expected set=7 clr=1", n_set - s_set, n_clr - s_clr); end
        checks++; if (n_att - s_att !== 8) begin errors++; $display("FAIL exhaust_attempts: got %0d expected 8", n_att - s_att); end
        finish_done;
    endtask

    task automatic test_stall;
        bit to; int bad_att, bad_done;
        bad_att = 0; bad_done = 0; bo_load = 0;
        att_ready = 1'b0;
        start_req(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (att_valid !== 1'b1 || att_data !== 32'h1234_5678 || req_ready !== 1'b0) bad_att++;
        end
        checks++; if (bad_att != 0) begin errors++; $display("FAIL stall_att_hold: got %0d bad cycles expected 0", bad_att); end
        @(posedge clk); #1;
        att_ready = 1'b1;
        wait_att(to);
        respond(1'b1);
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL stall_done: got timeout expected done"); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_valid !== 1'b1 || done_err !== 1'b0 || done_retries !== 3'd0 || req_ready !== 1'b0) bad_done++;
        end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL stall_done_hold: got %0d bad cycles expected 0", bad_done); end
        done_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_no_same_cycle_accept: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        done_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL stall_back_to_idle: got ready=%b done=%b expected ready=1 done=0", req_ready, done_valid); end
    endtask

    task automatic test_spurious;
        int s_set, s_clr; bit to;
        s_set = n_set; s_clr = n_clr;
        // IDLE
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_ok = 1'b0;
        @(negedge clk);
        checks++; if ({backoff_set, backoff_clr} !== 2'b00 || req_ready !== 1'b1) begin errors++; $display("FAIL spur_idle: got set/clr=%b ready=%b expected 00/1", {backoff_set, backoff_clr}, req_ready); end
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || att_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_state: got ready=%b att=%b expected 1/0", req_ready, att_valid); end
        // BACKOFF
        bo_load = 6;
        start_req(32'h5555_AAAA);
        wait_att(to);
        respond(1'b0);
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_ok = 1'b1;
        @(negedge clk);
        checks++; if ({backoff_set, backoff_clr} !== 2'b00 || att_valid !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL spur_backoff: got set/clr=%b att=%b done=%b expected 00/0/0", {backoff_set, backoff_clr}, att_valid, done_valid); end
        @(posedge clk); #1;
        rsp_valid = 1'b0; rsp_ok = 1'b0;
        wait_att(to);
        respond(1'b1);
        wait_done(to);
        checks++; if (to || done_retries !== 3'd1 || done_err !== 1'b0) begin errors++; $display("FAIL spur_backoff_status: got ret=%0d err=%b (to=%0b) expected ret=1 err=0", done_retries, done_err, to); end
        // DONE
        rsp_valid = 1'b1; rsp_ok = 1'b0;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (done_valid !== 1'b1 || done_retries !== 3'd1) begin errors++; $display("FAIL spur_done_hold: got valid=%b ret=%0d expected 1/1", done_valid, done_retries); end
        checks++; if (n_set - s_set !== 1 || n_clr - s_clr !== 1) begin errors++; $display("FAIL spur_pulses: got set=%0d clr=%0d expected set=1 clr=1", n_set - s_set, n_clr - s_clr); end
        finish_done;
    endtask

    task automatic test_reset_mid;
        bit to; bit any_to;
        bo_load = 10; any_to = 0;
        start_req(32'hCAFE_0003);
        for (int a = 0; a < 3; a++) begin
            wait_att(to); any_to |= to;
            respond(1'b0);
        end
        @(posedge clk); #1;   // now in BACKOFF with counter loaded
        rst = 1'b1;
        #1;
        checks++; if (any_to || req_ready !== 1'b1 || att_valid !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got ready=%b att=%b done=%b (to=%0b) expected 1/0/0", req_ready, att_valid, done_valid, any_to); end
        checks++; if ({backoff_set, backoff_clr} !== 2'b00 || att_data !== '0) begin errors++; $display("FAIL midrst_regs: got set/clr=%b data=%0h expected 00/0", {backoff_set, backoff_clr}, att_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        bo_load = 0; any_to = 0;
        start_req(32'h0000_BEEF);
        wait_att(to); any_to |= to;
        respond(1'b0);
        wait_att(to); any_to |= to;
        respond(1'b1);
        wait_done(to); any_to |= to;
        checks++; if (any_to || (cyc - acc_cyc) !== 7) begin errors++; $display("FAIL midrst_latency: got %0d (to=%0b) expected 7", cyc - acc_cyc, any_to); end
        checks++; if ({done_err, done_retries} !== {1'b0, 3'd1}) begin errors++; $display("FAIL midrst_status: got err=%b ret=%0d expected err=0 ret=1", done_err, done_retries); end
        finish_done;
    endtask

    initial begin
        test_reset();
        test_single_ok();
        test_fail_then_ok();
        test_exhaust();
        test_stall();
        test_spurious();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_backoff_retry_ctrl
`default_nettype wire
